// File: rtl/alu_pkg.sv
// Shared ALU definitions: FunctC codes, ALUOp and MIPS funct codes, and the
// sequencer FSM state encoding.
package alu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned FUNCTC_W = 4;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned STATE_W  = 2;

  // FunctC codes understood by the ALU
  localparam logic [FUNCTC_W-1:0] FUNCTC_ADD = 4'b0010;
  localparam logic [FUNCTC_W-1:0] FUNCTC_SUB = 4'b0110;
  localparam logic [FUNCTC_W-1:0] FUNCTC_AND = 4'b0000;
  localparam logic [FUNCTC_W-1:0] FUNCTC_OR  = 4'b0001;
  localparam logic [FUNCTC_W-1:0] FUNCTC_NOR = 4'b0011;
  localparam logic [FUNCTC_W-1:0] FUNCTC_XOR = 4'b0100;
  localparam logic [FUNCTC_W-1:0] FUNCTC_MUL = 4'b1010;
  localparam logic [FUNCTC_W-1:0] FUNCTC_DIV = 4'b1111;

  // ALUOp from the main decoder
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;

  // MIPS funct field values
  localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB  = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR  = 6'b100111;
  localparam logic [FUNCT_W-1:0] FUNCT_XOR  = 6'b100110;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT = 6'b011000;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV  = 6'b011010;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 6'b101010;

  // Sequencer FSM states
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_EXEC = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode: ALUOp + funct -> FunctC and op class.
// Ports: aluop, funct in; functc, illegal, is_slt, is_mul, is_div out.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] functc,
  output logic       illegal,
  output logic       is_slt,
  output logic       is_mul,
  output logic       is_div
);

  always_comb begin
    functc  = FUNCTC_ADD;
    illegal = 1'b0;
    is_slt  = 1'b0;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    case (aluop)
      ALUOP_ADD: functc = FUNCTC_ADD;
      ALUOP_SUB: functc = FUNCTC_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD:  functc = FUNCTC_ADD;
          FUNCT_SUB:  functc = FUNCTC_SUB;
          FUNCT_AND:  functc = FUNCTC_AND;
          FUNCT_OR:   functc = FUNCTC_OR;
          FUNCT_NOR:  functc = FUNCTC_NOR;
          FUNCT_XOR:  functc = FUNCTC_XOR;
          FUNCT_MULT: begin functc = FUNCTC_MUL; is_mul = 1'b1; end
          FUNCT_DIV:  begin functc = FUNCTC_DIV; is_div = 1'b1; end
          // slt runs as a subtract; the sign is extracted at capture
          FUNCT_SLT:  begin functc = FUNCTC_SUB; is_slt = 1'b1; end
          default:    illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator-side ALU sequencer: accepts a decoded op, drives FunctC/A/B to a
// shared ALU for the op's latency, captures the result and returns it.
// Ports: clk, rst_n; in_valid/in_ready/in_aluop/in_funct/in_a/in_b (request);
// alu_functc/alu_a/alu_b out, alu_out/alu_zero in (ALU side);
// out_valid/out_ready/out_result/out_zero/out_err (response).
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned LAT_FAST = 1,
  parameter int unsigned LAT_MUL  = 4,
  parameter int unsigned LAT_DIV  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_aluop,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [3:0]  alu_functc,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_err
);

  localparam int unsigned LAT_MAX =
    (LAT_DIV > LAT_MUL) ? ((LAT_DIV > LAT_FAST) ? LAT_DIV : LAT_FAST)
                        : ((LAT_MUL > LAT_FAST) ? LAT_MUL : LAT_FAST);
  localparam int unsigned CNT_W = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  logic [3:0] dec_functc;
  logic       dec_illegal;
  logic       dec_slt;
  logic       dec_mul;
  logic       dec_div;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               slt_q, slt_d;
  logic [3:0]         functc_d;
  logic [31:0]        a_d, b_d;
  logic [31:0]        result_d;
  logic               zero_d, err_d;

  alu_ctrl_decode u_decode (
    .aluop   (in_aluop),
    .funct   (in_funct),
    .functc  (dec_functc),
    .illegal (dec_illegal),
    .is_slt  (dec_slt),
    .is_mul  (dec_mul),
    .is_div  (dec_div)
  );

  // Next-state, counter, ALU drive and result capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    slt_d    = slt_q;
    functc_d = alu_functc;
    a_d      = alu_a;
    b_d      = alu_b;
    result_d = out_result;
    zero_d   = out_zero;
    err_d    = out_err;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (dec_illegal) begin
            state_d  = ST_DONE;
            result_d = '0;
            zero_d   = 1'b1;
            err_d    = 1'b1;
          end else if (dec_div && (in_b == '0)) begin
            state_d  = ST_DONE;
            result_d = '1;
            zero_d   = 1'b0;
            err_d    = 1'b1;
          end else begin
            state_d  = ST_EXEC;
            functc_d = dec_functc;
            a_d      = in_a;
            b_d      = in_b;
            slt_d    = dec_slt;
            if (dec_div)      cnt_d = CNT_W'(LAT_DIV - 1);
            else if (dec_mul) cnt_d = CNT_W'(LAT_MUL - 1);
            else              cnt_d = CNT_W'(LAT_FAST - 1);
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          // slt: result is the sign of a-b, zero flag follows that bit
          if (slt_q) begin
            result_d = DATA_W'(alu_out[DATA_W-1]);
            zero_d   = ~alu_out[DATA_W-1];
          end else begin
            result_d = alu_out;
            zero_d   = alu_zero;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; handshake flags follow the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      slt_q      <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_err    <= 1'b0;
      alu_functc <= FUNCTC_ADD;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      slt_q      <= slt_d;
      in_ready   <= (state_d == ST_IDLE);
      out_valid  <= (state_d == ST_DONE);
      out_result <= result_d;
      out_zero   <= zero_d;
      out_err    <= err_d;
      alu_functc <= functc_d;
      alu_a      <= a_d;
      alu_b      <= b_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU attached.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_aluop;
  logic [5:0]  in_funct;
  logic [31:0] in_a, in_b;
  logic [3:0]  alu_functc;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_err;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  alu_op_sequencer #(.LAT_FAST(1), .LAT_MUL(4), .LAT_DIV(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_aluop   (in_aluop),
    .in_funct   (in_funct),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_functc (alu_functc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU on the other side of the sequencer
  always_comb begin
    case (alu_functc)
      4'b0010: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0011: alu_out = ~(alu_a | alu_b);
      4'b0100: alu_out = alu_a ^ alu_b;
      4'b1010: alu_out = {16'h0, alu_a[15:0]} * {16'h0, alu_b[15:0]};
      4'b1111: alu_out = (alu_b == 32'h0) ? 32'hFFFF_FFFF : alu_a / alu_b;
      default: alu_out = 32'h0;
    endcase
    alu_zero = (alu_out == 32'h0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted response against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_response", out_result, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_result", out_result, e.result);
        chk("out_zero", 32'(out_zero), 32'(e.zero));
        chk("out_err", 32'(out_err), 32'(e.err));
      end
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Issue one op, push its expectation, then check latency and ready timing
  task automatic do_op(input string name, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez, input logic ee,
                       input logic [3:0] efc, input bit chk_fc, input int elat);
    int lat;
    bit low_ok;
    bit fc_ok;
    wait_ready(name);
    in_valid = 1'b1;
    in_aluop = op;
    in_funct = fn;
    in_a     = a;
    in_b     = b;
    exp_q.push_back('{result: er, zero: ez, err: ee});
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat    = 1;
    low_ok = 1'b1;
    fc_ok  = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) low_ok = 1'b0;
      if (alu_functc !== efc) fc_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) low_ok = 1'b0;
    if (alu_functc !== efc) fc_ok = 1'b0;
    chk({name, "_latency"}, 32'(lat), 32'(elat));
    chk({name, "_ready_low"}, 32'(low_ok), 32'd1);
    if (chk_fc) chk({name, "_functc_held"}, 32'(fc_ok), 32'd1);
    @(posedge clk); #1;
    chk({name, "_ready_back"}, 32'(in_ready), 32'd1);
    chk({name, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    bit stable;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_aluop  = 2'b00;
    in_funct  = 6'b0;
    in_a      = 32'h0;
    in_b      = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_functc", 32'(alu_functc), 32'h2);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // name, aluop, funct, a, b, result, zero, err, functc, check functc, latency
    do_op("add",  2'b10, 6'b100000, 32'd5,      32'd7,      32'd12,        1'b0, 1'b0, 4'b0010, 1, 2);
    do_op("beq",  2'b01, 6'b000000, 32'h1234,   32'h1234,   32'd0,         1'b1, 1'b0, 4'b0110, 1, 2);
    do_op("slt1", 2'b10, 6'b101010, 32'd3,      32'd9,      32'd1,         1'b0, 1'b0, 4'b0110, 1, 2);
    do_op("slt0", 2'b10, 6'b101010, 32'd9,      32'd3,      32'd0,         1'b1, 1'b0, 4'b0110, 1, 2);
    do_op("and",  2'b10, 6'b100100, 32'hF0F0,   32'hFF00,   32'h0000_F000, 1'b0, 1'b0, 4'b0000, 1, 2);
    do_op("nor",  2'b10, 6'b100111, 32'h0,      32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0, 4'b0011, 1, 2);
    do_op("lw",   2'b00, 6'b000000, 32'h100,    32'h20,     32'h120,       1'b0, 1'b0, 4'b0010, 1, 2);
    do_op("div",  2'b10, 6'b011010, 32'd100,    32'd7,      32'd14,        1'b0, 1'b0, 4'b1111, 1, 17);
    do_op("div0", 2'b10, 6'b011010, 32'd100,    32'd0,      32'hFFFF_FFFF, 1'b0, 1'b1, 4'b1111, 0, 1);
    do_op("ill11",2'b11, 6'b100000, 32'd1,      32'd2,      32'd0,         1'b1, 1'b1, 4'b1111, 1, 1);
    do_op("illfn",2'b10, 6'b001000, 32'd1,      32'd2,      32'd0,         1'b1, 1'b1, 4'b1111, 1, 1);

    // Backpressure on a mult; a second request must wait for the handshake
    out_ready = 1'b0;
    wait_ready("mul_bp");
    in_valid = 1'b1;
    in_aluop = 2'b10;
    in_funct = 6'b011000;
    in_a     = 32'h0001_0003;
    in_b     = 32'h4;
    exp_q.push_back('{result: 32'd12, zero: 1'b0, err: 1'b0});
    @(posedge clk); #1;
    chk("mul_functc", 32'(alu_functc), 32'hA);
    in_aluop = 2'b00;
    in_funct = 6'b0;
    in_a     = 32'd1;
    in_b     = 32'd1;
    seen = 0;
    while (!out_valid && seen < 40) begin
      @(posedge clk); #1;
      seen++;
    end
    chk("mul_latency", 32'(seen + 1), 32'd5);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid || in_ready || out_result !== 32'd12 || out_zero !== 1'b0 || out_err !== 1'b0)
        stable = 1'b0;
      @(posedge clk); #1;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    exp_q.push_back('{result: 32'd2, zero: 1'b0, err: 1'b0});
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_after_hs", 32'(in_ready), 32'd1);
    chk("bp_no_early_accept", 32'(alu_functc), 32'hA);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_new_accept", 32'(alu_functc), 32'h2);
    seen = 0;
    while (!out_valid && seen < 40) begin
      @(posedge clk); #1;
      seen++;
    end
    chk("bp_add_latency", 32'(seen + 1), 32'd2);
    @(posedge clk); #1;

    // Reset in the middle of a div: the op is dropped silently
    wait_ready("rst_div");
    in_valid = 1'b1;
    in_aluop = 2'b10;
    in_funct = 6'b011010;
    in_a     = 32'd100;
    in_b     = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_functc", 32'(alu_functc), 32'h2);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("post_rst_no_output", 32'(seen), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
